// File: rtl/axi_wr_mux_pkg.sv
// Shared definitions for the AXI write-channel slave-side multiplexer.
// Holds the AWCTL bundle layout {len4,size3,burst2,lock2,cache4,prot3}
// and the address-channel FSM state type.
package axi_wr_mux_pkg;

  localparam int unsigned AWCTL_W         = 18;

  localparam int unsigned AWCTL_PROT_W    = 3;
  localparam int unsigned AWCTL_PROT_LSB  = 0;
  localparam int unsigned AWCTL_CACHE_W   = 4;
  localparam int unsigned AWCTL_CACHE_LSB = 3;
  localparam int unsigned AWCTL_LOCK_W    = 2;
  localparam int unsigned AWCTL_LOCK_LSB  = 7;
  localparam int unsigned AWCTL_BURST_W   = 2;
  localparam int unsigned AWCTL_BURST_LSB = 9;
  localparam int unsigned AWCTL_SIZE_W    = 3;
  localparam int unsigned AWCTL_SIZE_LSB  = 11;
  localparam int unsigned AWCTL_LEN_W     = 4;
  localparam int unsigned AWCTL_LEN_LSB   = 14;

  typedef enum logic {
    AW_IDLE,
    AW_GRANT
  } aw_state_e;

endpackage

// File: rtl/axi_wr_order_fifo.sv
// Write-order FIFO: records which master won each AW handshake so the W
// channel can be steered in the same order.
// Ports: clk, reset_n (async, active-low), push_i/data_i (write side),
//        pop_i/data_o (read side, data_o is the current head),
//        full_o, empty_o.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module axi_wr_order_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [PTR_W:0]   cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= data_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        wr_q <= wr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_q <= rd_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (PTR_W+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PTR_W+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/axi_wr_mux_n.sv
// N-master to one-slave AXI write multiplexer (AW + W channels).
// A master requests this slave when its AWADDR select field matches sel.
// One AW is granted at a time; each AW handshake records the winner in an
// order FIFO whose head steers the W channel, so W beats follow AW order.
// Ports: clk, reset_n (async, active-low), sel; per-master AW/W inputs
//        m_* (flattened, master i at slice i) with m_awready/m_wready;
//        slave AW/W outputs s_* with s_awready/s_wready. s_awid/s_wid are
//        {master index, ID}.
// Build option: define AXI_WR_MUX_RR_EN for round-robin arbitration;
//        otherwise fixed priority, lowest master index wins.
module axi_wr_mux_n
  import axi_wr_mux_pkg::*;
#(
  parameter int unsigned NUM_M   = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ID_W    = 4,
  parameter int unsigned SEL_LSB = 10,
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [SEL_W-1:0]                    sel,
  input  logic [NUM_M*ADDR_W-1:0]             m_awaddr,
  input  logic [NUM_M*ID_W-1:0]               m_awid,
  input  logic [NUM_M*AWCTL_W-1:0]            m_awctl,
  input  logic [NUM_M-1:0]                    m_awvalid,
  output logic [NUM_M-1:0]                    m_awready,
  input  logic [NUM_M*ID_W-1:0]               m_wid,
  input  logic [NUM_M*DATA_W-1:0]             m_wdata,
  input  logic [NUM_M*(DATA_W/8)-1:0]         m_wstrb,
  input  logic [NUM_M-1:0]                    m_wlast,
  input  logic [NUM_M-1:0]                    m_wvalid,
  output logic [NUM_M-1:0]                    m_wready,
  output logic [ADDR_W-1:0]                   s_awaddr,
  output logic [AWCTL_W-1:0]                  s_awctl,
  output logic [$clog2(NUM_M)+ID_W-1:0]       s_awid,
  output logic                                s_awvalid,
  input  logic                                s_awready,
  output logic [$clog2(NUM_M)+ID_W-1:0]       s_wid,
  output logic [DATA_W-1:0]                   s_wdata,
  output logic [DATA_W/8-1:0]                 s_wstrb,
  output logic                                s_wlast,
  output logic                                s_wvalid,
  input  logic                                s_wready
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDX_W  = $clog2(NUM_M);

  aw_state_e        state_q;
  logic [IDX_W-1:0] grant_q;
  logic [NUM_M-1:0] req;
  logic             win_vld;
  logic [IDX_W-1:0] win_idx;
  logic             aw_hs;
  logic             w_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [IDX_W-1:0] head;

  always_comb begin
    req = '0;
    for (int unsigned i = 0; i < NUM_M; i++) begin
      req[i] = m_awvalid[i] && (m_awaddr[i*ADDR_W+SEL_LSB +: SEL_W] == sel);
    end
  end

`ifdef AXI_WR_MUX_RR_EN
  logic [IDX_W-1:0] rr_q;

  // Search starts at rr_q and wraps, so the first hit is the RR winner.
  always_comb begin
    int unsigned j;
    j       = 0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int unsigned k = 0; k < NUM_M; k++) begin
      j = (32'(rr_q) + k) % NUM_M;
      if (!win_vld && req[j]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'(j);
      end
    end
  end
`else
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int unsigned k = 0; k < NUM_M; k++) begin
      if (!win_vld && req[k]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'(k);
      end
    end
  end
`endif

  assign aw_hs = (state_q == AW_GRANT) && s_awready;

  // Grant is held until the handshake even if the master drops its request.
  // The full check uses the registered count, so a same-cycle pop does not
  // open a slot for a new grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= AW_IDLE;
      grant_q <= '0;
`ifdef AXI_WR_MUX_RR_EN
      rr_q    <= '0;
`endif
    end else begin
      case (state_q)
        AW_IDLE: begin
          if (win_vld && !fifo_full) begin
            grant_q <= win_idx;
            state_q <= AW_GRANT;
          end
        end
        AW_GRANT: begin
          if (s_awready) begin
            state_q <= AW_IDLE;
`ifdef AXI_WR_MUX_RR_EN
            rr_q    <= (grant_q == IDX_W'(NUM_M-1)) ? '0 : grant_q + IDX_W'(1);
`endif
          end
        end
      endcase
    end
  end

  always_comb begin
    s_awvalid = 1'b0;
    s_awaddr  = '0;
    s_awctl   = '0;
    s_awid    = '0;
    m_awready = '0;
    if (state_q == AW_GRANT) begin
      s_awvalid          = 1'b1;
      s_awaddr           = m_awaddr[32'(grant_q)*ADDR_W +: ADDR_W];
      s_awctl            = m_awctl[32'(grant_q)*AWCTL_W +: AWCTL_W];
      s_awid             = {grant_q, m_awid[32'(grant_q)*ID_W +: ID_W]};
      m_awready[grant_q] = s_awready;
    end
  end

  always_comb begin
    s_wvalid = 1'b0;
    s_wdata  = '0;
    s_wstrb  = '0;
    s_wlast  = 1'b0;
    s_wid    = '0;
    m_wready = '0;
    if (!fifo_empty) begin
      s_wvalid       = m_wvalid[head];
      s_wdata        = m_wdata[32'(head)*DATA_W +: DATA_W];
      s_wstrb        = m_wstrb[32'(head)*STRB_W +: STRB_W];
      s_wlast        = m_wlast[head];
      s_wid          = {head, m_wid[32'(head)*ID_W +: ID_W]};
      m_wready[head] = s_wready;
    end
  end

  assign w_pop = s_wvalid && s_wready && s_wlast;

  axi_wr_order_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (DEPTH)
  ) u_order_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (aw_hs),
    .data_i  (grant_q),
    .pop_i   (w_pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: doc/axi_wr_mux_n.md
AXI_WR_MUX_N -- requirements
Module: axi_wr_mux_n

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- NUM_M, 4: number of master ports (2..8).
- ADDR_W, 32: address width.
- DATA_W, 32: write-data width; STRB_W = DATA_W/8.
- ID_W, 4: master-side ID width.
- SEL_LSB, 10: low bit of the address slave-select field.
- SEL_W, 3: width of the slave-select field.
- DEPTH, 4: write-order FIFO depth, power of 2.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- sel  in  SEL_W  slave number this mux serves.
- m_awaddr  in  NUM_M*ADDR_W  per-master AWADDR.
- m_awid  in  NUM_M*ID_W  per-master AWID.
- m_awctl  in  NUM_M*18  per-master {len4,size3,burst2,lock2,cache4,prot3}.
- m_awvalid  in  NUM_M  per-master AWVALID.
- m_awready  out  NUM_M  per-master AWREADY.
- m_wid  in  NUM_M*ID_W  per-master WID.
- m_wdata  in  NUM_M*DATA_W  per-master WDATA.
- m_wstrb  in  NUM_M*STRB_W  per-master WSTRB.
- m_wlast  in  NUM_M  per-master WLAST.
- m_wvalid  in  NUM_M  per-master WVALID.
- m_wready  out  NUM_M  per-master WREADY.
- s_awaddr/s_awctl  out  ADDR_W/18  slave AW payload.
- s_awid  out  ID_W+IDX_W  {master index, AWID}; IDX_W = clog2(NUM_M).
- s_awvalid  out  1  slave AWVALID.
- s_awready  in  1  slave AWREADY.
- s_wid  out  ID_W+IDX_W  {master index, WID}.
- s_wdata/s_wstrb/s_wlast  out  DATA_W/STRB_W/1  slave W payload.
- s_wvalid  out  1  slave WVALID.
- s_wready  in  1  slave WREADY.

Function
REQ-003 req[i] SHALL be m_awvalid[i] & (m_awaddr[i][SEL_LSB +: SEL_W] == sel).
REQ-004 The AW FSM SHALL have two states. IDLE: with any req and FIFO not full, register the winner, go to GRANT. GRANT: on s_awvalid & s_awready, return to IDLE.
REQ-005 In GRANT, s_awvalid SHALL be 1 and AW payload SHALL be the granted master's; all AW outputs SHALL be 0 in IDLE.
REQ-006 Only the granted master's m_awready SHALL equal s_awready; all others SHALL be 0.
REQ-007 AW latency: req seen at edge N gives s_awvalid high from cycle N+1; at most one AW handshake every 2 cycles.
REQ-008 The AW handshake SHALL push the granted index into the order FIFO; no grant SHALL be issued while the FIFO is full, even if a pop occurs in the same cycle.
REQ-009 With the FIFO non-empty, the head index h SHALL route m_w*[h] to s_w* combinationally; m_wready[h] = s_wready; all other m_wready = 0.
REQ-010 With the FIFO empty, s_wvalid and all m_wready SHALL be 0 and the W payload 0; W data SHALL never precede its AW handshake.
REQ-011 The order FIFO SHALL pop on s_wvalid & s_wready & s_wlast; pointers wrap mod DEPTH; count range 0..DEPTH.
REQ-012 A simultaneous push and pop SHALL leave the count unchanged.
REQ-013 A granted master whose req drops before handshake is an AXI violation; the grant SHALL be held regardless.

Reset
REQ-014 On reset_n low, asynchronously: FSM to IDLE, grant 0, FIFO empty, rr pointer 0; all outputs 0.
REQ-015 Reset mid-burst SHALL abort the burst; no recovery is attempted.

Configuration
REQ-016 With AXI_WR_MUX_RR_EN defined, arbitration SHALL be round-robin: search starts at rr pointer, which becomes winner+1 (mod NUM_M) on each AW handshake.
REQ-017 Without AXI_WR_MUX_RR_EN, arbitration SHALL be fixed priority (lowest index wins) and no rr pointer SHALL exist.

Structure
REQ-018 Package axi_wr_mux_pkg SHALL hold the AWCTL field widths/offsets (AWCTL_W = 18) and the FSM state enum.
REQ-019 The order FIFO SHALL be sub-module axi_wr_order_fifo (params WIDTH, DEPTH; full/empty outputs).

Verification
REQ-020 Scenarios:
- M0 AW addr 0x0000_0C00, sel = 3, len = 3 -> s_awid = {0, id}; 4 W beats pass; FIFO empties after WLAST.
- M1 and M2 request together in RR mode -> grants M1, M2, M1, M2; fixed priority -> M1 repeatedly.
- M0 address field 2, sel = 3 -> s_awvalid stays 0 and m_awready[0] = 0.
- 4 AWs with no W (DEPTH = 4) -> 5th AW not granted until the first WLAST pops.
- M2 W data presented before its AW -> m_wready[2] = 0 until the AW handshake completes.
- reset_n low during beat 2 of 4 -> all outputs 0 that cycle, FIFO empty, FSM IDLE.
